// File: rtl/npu_isa_pkg.sv
// NPU instruction-set constants shared by the fetch stage and the decoder,
// plus the fetch FSM state encoding.
package npu_isa_pkg;

    localparam int OPCODE_MSB = 127;
    localparam int OPCODE_W   = 5;

    localparam logic [OPCODE_W-1:0] IOB2N = 5'b01010;
    localparam logic [OPCODE_W-1:0] WB2N  = 5'b01011;
    localparam logic [OPCODE_W-1:0] N2IOB = 5'b01101;

    localparam logic [2:0] FS_IDLE   = 3'd0;
    localparam logic [2:0] FS_FETCH  = 3'd1;
    localparam logic [2:0] FS_WAIT   = 3'd2;
    localparam logic [2:0] FS_ISSUE  = 3'd3;
    localparam logic [2:0] FS_LAUNCH = 3'd4;
    localparam logic [2:0] FS_RUN    = 3'd5;
    localparam logic [2:0] FS_FIN    = 3'd6;

    function automatic logic op_is_legal(input logic [OPCODE_W-1:0] op);
        return (op == IOB2N) || (op == WB2N) || (op == N2IOB);
    endfunction

endpackage

// File: rtl/npu_inst_fetch.sv
// Instruction fetch: streams a block of instructions to the decoder, launching the
// NPU core after each N2IOB group. Optional NPU_FETCH_OPCODE_CHECK_EN flags illegal opcodes.
module npu_inst_fetch
    import npu_isa_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int INST_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_inst_base,
    input  logic [ADDR_W-1:0] i_inst_num,
    output logic              o_imem_en,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic [INST_W-1:0] i_imem_rdata,
    output logic [INST_W-1:0] o_inst,
    output logic              o_inst_valid,
    output logic              o_npu_start,
    input  logic              i_npu_done,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [ADDR_W-1:0] rem_q,   rem_d;
    logic [INST_W-1:0] inst_q,  inst_d;
    logic              vld_q,   vld_d;
    logic              done_q,  done_d;
    logic              rd_bad;

    logic [OPCODE_W-1:0] iss_op;
    assign iss_op = inst_q[INST_W-1 -: OPCODE_W];

`ifdef NPU_FETCH_OPCODE_CHECK_EN
    logic [OPCODE_W-1:0] rd_op;
    logic                err_q, err_d;
    assign rd_op  = i_imem_rdata[INST_W-1 -: OPCODE_W];
    assign rd_bad = (state_q == FS_WAIT) && !op_is_legal(rd_op);

    // Sticky until a new program is accepted.
    always_comb begin
        err_d = err_q;
        if (state_q == FS_IDLE && i_start) err_d = 1'b0;
        if (rd_bad)                        err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign o_err = err_q;
`else
    assign rd_bad = 1'b0;
    assign o_err  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FS_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            inst_q  <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            inst_q  <= inst_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FS_IDLE:   if (i_start) state_d = (i_inst_num == '0) ? FS_FIN : FS_FETCH;
            FS_FETCH:  state_d = FS_WAIT;
            FS_WAIT:   state_d = rd_bad ? FS_FIN : FS_ISSUE;
            FS_ISSUE: begin
                if (iss_op == N2IOB)   state_d = FS_LAUNCH;
                else if (rem_q == '0)  state_d = FS_FIN;
                else                   state_d = FS_FETCH;
            end
            FS_LAUNCH: state_d = FS_RUN;
            FS_RUN:    if (i_npu_done) state_d = (rem_q == '0) ? FS_FIN : FS_FETCH;
            FS_FIN:    state_d = FS_IDLE;
            default:   state_d = FS_IDLE;
        endcase
    end

    // Counters advance in WAIT so ISSUE already sees the post-read remainder.
    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        inst_d = inst_q;
        vld_d  = 1'b0;
        done_d = (state_q == FS_FIN);
        case (state_q)
            FS_IDLE: begin
                if (i_start) begin
                    addr_d = i_inst_base;
                    rem_d  = i_inst_num;
                end
            end
            FS_WAIT: begin
                addr_d = addr_q + 1'b1;
                rem_d  = rem_q - 1'b1;
                if (!rd_bad) begin
                    inst_d = i_imem_rdata;
                    vld_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        o_imem_en   = (state_q == FS_FETCH);
        o_imem_addr = addr_q;
        o_npu_start = (state_q == FS_LAUNCH);
        o_busy      = (state_q != FS_IDLE);
        o_inst      = inst_q;
        o_inst_valid = vld_q;
        o_done      = done_q;
    end

endmodule

// File: tb/tb_npu_inst_fetch.sv
// Scoreboard bench for npu_inst_fetch: expected addresses/instructions queued at
// stimulus time, compared as the DUT emits them; strobe timing checked per run.
module tb_npu_inst_fetch;
    import npu_isa_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_start = 1'b0;
    logic [11:0]  i_inst_base = '0;
    logic [11:0]  i_inst_num = '0;
    logic         o_imem_en;
    logic [11:0]  o_imem_addr;
    logic [127:0] i_imem_rdata = '0;
    logic [127:0] o_inst;
    logic         o_inst_valid;
    logic         o_npu_start;
    logic         i_npu_done = 1'b0;
    logic         o_busy;
    logic         o_done;
    logic         o_err;

    npu_inst_fetch #(.ADDR_W(12), .INST_W(128)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_inst_base(i_inst_base),
        .i_inst_num(i_inst_num), .o_imem_en(o_imem_en), .o_imem_addr(o_imem_addr),
        .i_imem_rdata(i_imem_rdata), .o_inst(o_inst), .o_inst_valid(o_inst_valid),
        .o_npu_start(o_npu_start), .i_npu_done(i_npu_done), .o_busy(o_busy),
        .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [127:0] mem [0:4095];
    always @(posedge clk) if (o_imem_en) i_imem_rdata <= mem[o_imem_addr];

    int total = 0;
    int bad = 0;
    int t0 = 0;
    int st_last = -1000;
    bit done_seen = 1'b0;
    logic [11:0]  exp_addr[$];
    logic [127:0] exp_inst[$];
    int vq[$];
    int sq[$];
    int dq[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_list(input string tag, input int got[$], input int n,
                            input int a, input int b, input int c);
        int e[3];
        e[0] = a; e[1] = b; e[2] = c;
        chk({tag, "_n"}, 128'(got.size()), 128'(n));
        for (int i = 0; i < n && i < got.size(); i++)
            chk(tag, 128'(got[i]), 128'(e[i]));
    endtask

    always @(negedge clk) if (!rst) begin
        if (o_imem_en) begin
            if (exp_addr.size() == 0) chk("unexp_en", 128'(o_imem_addr), 128'(0));
            else chk("addr", 128'(o_imem_addr), 128'(exp_addr.pop_front()));
        end
        if (o_inst_valid) begin
            vq.push_back(cyc - t0);
            if (exp_inst.size() == 0) chk("unexp_valid", o_inst, 128'(0));
            else chk("inst", o_inst, exp_inst.pop_front());
        end
        if (o_npu_start) begin
            sq.push_back(cyc - t0);
            st_last = cyc - t0;
        end
        if (o_done) begin
            dq.push_back(cyc - t0);
            done_seen = 1'b1;
        end
    end

    task automatic put(input logic [11:0] a, input logic [4:0] op, input bit pa, input bit pi);
        logic [127:0] w;
        w = {$urandom, $urandom, $urandom, $urandom};
        w[127:123] = op;
        mem[a] = w;
        if (pa) exp_addr.push_back(a);
        if (pi) exp_inst.push_back(w);
    endtask

    // Drives one program; xs/xd are relative cycles for a stray i_start / i_npu_done,
    // rr the relative cycle at which reset is slammed in (-1 = none).
    task automatic run(input string tag, input logic [11:0] base, input logic [11:0] num,
                       input int dly, input int xs, input int xd, input int rr);
        int rel;
        vq.delete(); sq.delete(); dq.delete();
        st_last = -1000;
        done_seen = 1'b0;
        t0 = cyc;
        for (int k = 0; k < 300; k++) begin
            rel = cyc - t0;
            i_start     = (rel == 0) || (rel == xs);
            i_inst_base = (rel == xs) ? 12'h100 : base;
            i_inst_num  = (rel == xs) ? 12'd7 : num;
            i_npu_done  = (rel == xd) || (rel == st_last + dly);
            if (rel == rr) begin
                chk({tag, "_busy_pre"}, 128'(o_busy), 128'(1));
                rst = 1'b1;
                #1;
                chk({tag, "_rst_busy"},  128'(o_busy), 128'(0));
                chk({tag, "_rst_start"}, 128'(o_npu_start), 128'(0));
                chk({tag, "_rst_en"},    128'(o_imem_en), 128'(0));
                chk({tag, "_rst_valid"}, 128'(o_inst_valid), 128'(0));
                chk({tag, "_rst_inst"},  o_inst, 128'(0));
                i_start = 1'b0;
                i_npu_done = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (done_seen) break;
        end
        i_start = 1'b0;
        i_npu_done = 1'b0;
        if (!done_seen) chk({tag, "_timeout"}, 128'(0), 128'(1));
        chk({tag, "_exp_left"}, 128'(exp_addr.size() + exp_inst.size()), 128'(0));
    endtask

    task automatic load_t1();
        put(12'h010, IOB2N, 1, 1);
        put(12'h011, WB2N,  1, 1);
        put(12'h012, N2IOB, 1, 1);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  128'(o_busy), 128'(0));
        chk("rst_en",    128'(o_imem_en), 128'(0));
        chk("rst_valid", 128'(o_inst_valid), 128'(0));
        chk("rst_start", 128'(o_npu_start), 128'(0));
        chk("rst_done",  128'(o_done), 128'(0));
        chk("rst_err",   128'(o_err), 128'(0));
        chk("rst_inst",  o_inst, 128'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // T1: basic group with launch and done handshake
        load_t1();
        run("t1", 12'h010, 12'd3, 5, -1, -1, -1);
        chk_list("t1_valid", vq, 3, 3, 6, 9);
        chk_list("t1_launch", sq, 1, 10, 0, 0);
        chk_list("t1_done", dq, 1, 17, 0, 0);
        repeat (2) @(posedge clk); #1;

        // T2: empty program
        run("t2", 12'h040, 12'd0, 5, -1, -1, -1);
        chk_list("t2_valid", vq, 0, 0, 0, 0);
        chk_list("t2_launch", sq, 0, 0, 0, 0);
        chk_list("t2_done", dq, 1, 2, 0, 0);
        repeat (2) @(posedge clk); #1;

        // T3: address wrap, no trailing launch
        put(12'hFFF, IOB2N, 1, 1);
        put(12'h000, WB2N,  1, 1);
        run("t3", 12'hFFF, 12'd2, 5, -1, -1, -1);
        chk_list("t3_valid", vq, 2, 3, 6, 0);
        chk_list("t3_launch", sq, 0, 0, 0, 0);
        chk_list("t3_done", dq, 1, 8, 0, 0);
        repeat (2) @(posedge clk); #1;

        // T4: stray i_start in RUN and i_npu_done in FETCH are ignored
        load_t1();
        run("t4", 12'h010, 12'd3, 5, 12, 1, -1);
        chk_list("t4_valid", vq, 3, 3, 6, 9);
        chk_list("t4_launch", sq, 1, 10, 0, 0);
        chk_list("t4_done", dq, 1, 17, 0, 0);
        repeat (2) @(posedge clk); #1;

        // T5: reset during RUN, then replay
        load_t1();
        run("t5a", 12'h010, 12'd3, 100, -1, -1, 13);
        chk_list("t5a_valid", vq, 3, 3, 6, 9);
        chk_list("t5a_done", dq, 0, 0, 0, 0);
        exp_addr.delete(); exp_inst.delete();
        @(posedge clk); #1;
        load_t1();
        run("t5b", 12'h010, 12'd3, 5, -1, -1, -1);
        chk_list("t5b_valid", vq, 3, 3, 6, 9);
        chk_list("t5b_launch", sq, 1, 10, 0, 0);
        chk_list("t5b_done", dq, 1, 17, 0, 0);
        chk("t5_err", 128'(o_err), 128'(0));
        repeat (2) @(posedge clk); #1;

`ifdef NPU_FETCH_OPCODE_CHECK_EN
        // T6: illegal opcode aborts the program with a sticky error
        put(12'h020, IOB2N,  1, 1);
        put(12'h021, 5'h1F,  1, 0);
        put(12'h022, WB2N,   0, 0);
        run("t6", 12'h020, 12'd3, 5, -1, -1, -1);
        chk_list("t6_valid", vq, 1, 3, 0, 0);
        chk_list("t6_done", dq, 1, 7, 0, 0);
        chk("t6_err_set", 128'(o_err), 128'(1));
        repeat (3) @(posedge clk); #1;
        chk("t6_err_hold", 128'(o_err), 128'(1));
        run("t6b", 12'h000, 12'd0, 5, -1, -1, -1);
        chk("t6_err_clr", 128'(o_err), 128'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
